// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter and its round-robin picker.
package uart_tx_arbiter_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned TMO_W   = 8;

  localparam int unsigned REQ_REG   = 0;
  localparam int unsigned REQ_USB   = 1;
  localparam int unsigned REQ_FORCE = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  // Successor of g in a ring of n requesters.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] g, input int unsigned n);
    if ((32'(g) + 32'd1) >= n) return '0;
    return ID_W'(32'(g) + 32'd1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the packet sources, the arbiter and the UART Tx buffer.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 3
);
  import uart_tx_arbiter_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [BYTE_W*N_REQ-1:0] data;
  logic [N_REQ-1:0]        last;
  logic [N_REQ-1:0]        ack;
  logic                    UART_Tx_FULL;
  logic [BYTE_W-1:0]       UART_Tx_DATA;
  logic                    UART_send;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;
  logic                    timeout_err;
  logic                    err_clr;

  // Arbiter side.
  modport slave (
    input  req, data, last, UART_Tx_FULL, err_clr,
    output ack, UART_Tx_DATA, UART_send, grant_id, busy, timeout_err
  );

  // Sources / UART side.
  modport master (
    output req, data, last, UART_Tx_FULL, err_clr,
    input  ack, UART_Tx_DATA, UART_send, grant_id, busy, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above ptr_i, wrapping.
module uart_tx_arbiter_rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Rotate so that ptr_i lands on bit 0, then find the lowest set bit.
  assign rot = N'({req_i, req_i} >> ptr_i);

  always_comb begin
    off = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
  end

  assign found_o = |rot;
  assign sum     = (IDX_W+1)'(ptr_i) + (IDX_W+1)'(off);
  assign idx_o   = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : IDX_W'(sum);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding one UART Tx byte stream from N_REQ sources,
// with a per-packet stall timeout that revokes the grant and raises a sticky error.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              err_q, err_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              req_g;
  logic              last_g;
  logic [BYTE_W-1:0] data_g;
  logic              take;
  logic [N_REQ-1:0]  ack_c;

  uart_tx_arbiter_rr_pick #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Select the current owner's request lane.
  always_comb begin
    req_g  = 1'b0;
    last_g = 1'b0;
    data_g = bus.data[BYTE_W-1:0];
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_q == ID_W'(i)) begin
        req_g  = bus.req[i];
        last_g = bus.last[i];
        data_g = bus.data[BYTE_W*i +: BYTE_W];
      end
    end
  end

  // Next-state and transfer control.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    take      = 1'b0;

    if (bus.err_clr) err_d = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d   = pick_idx;
          tmo_cnt_d = '0;
          state_d   = ARB_XFER;
        end
      end
      ARB_XFER: begin
        take = req_g & ~bus.UART_Tx_FULL;
        if (take) begin
          tmo_cnt_d = '0;
          if (last_g) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = rr_next(grant_q, N_REQ);
          end
        end else if (!req_g) begin
          // A stalled owner loses the link; a set in this cycle overrides err_clr.
          if ((9'(tmo_cnt_q) + 9'd1) >= 9'(TIMEOUT)) begin
            state_d   = ARB_IDLE;
            rr_ptr_d  = rr_next(grant_q, N_REQ);
            tmo_cnt_d = '0;
            err_d     = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ack_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      ack_c[i] = take & (grant_q == ID_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= ID_W'(REQ_REG);
      rr_ptr_q  <= '0;
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.ack          = ack_c;
  assign bus.UART_send    = take;
  assign bus.UART_Tx_DATA = data_g;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = (state_q == ARB_XFER);
  assign bus.timeout_err  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: per-source packet queues drive the bus,
// a monitor checks every UART byte against hand-ordered expectations.
module tb_uart_tx_arbiter;

  localparam int unsigned N   = 3;
  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [8:0]  pq [N][$];   // {last, data} per source
  logic [10:0] expq[$];     // {id, data} in expected send order
  int          stamps[$];
  logic [N-1:0] ack_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    logic [8:0] f;
    for (int i = 0; i < int'(N); i++) begin
      if (pq[i].size() > 0) begin
        f = pq[i][0];
        bus.req[i]        = 1'b1;
        bus.data[8*i +: 8] = f[7:0];
        bus.last[i]       = f[8];
      end else begin
        bus.req[i]        = 1'b0;
        bus.data[8*i +: 8] = 8'h10 + 8'(i);
        bus.last[i]       = 1'b0;
      end
    end
  endtask

  task automatic tx(input int id, input logic [7:0] d, input logic l);
    pq[id].push_back({l, d});
  endtask

  task automatic expect_byte(input int id, input logic [7:0] d);
    expq.push_back({3'(id), d});
  endtask

  task automatic wait_send(input string nm);
    int k = 0;
    @(negedge clk);
    while (!bus.UART_send && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.UART_send) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    @(negedge clk);
    while ((expq.size() != 0 || bus.busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(expq.size() == 0 && !bus.busy), 32'd1);
  endtask

  always @(posedge clk) cyc++;

  // Source model: pop a byte when it was acked at the edge, then present the next one.
  always begin
    @(posedge clk);
    ack_s = bus.ack;
    #1;
    for (int i = 0; i < int'(N); i++) begin
      if (ack_s[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    end
    drive();
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [10:0] e;
    if (bus.UART_send) begin
      stamps.push_back(cyc);
      chk("exp_avail", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("send_id",   32'(bus.grant_id), 32'(e[10:8]));
        chk("send_data", 32'(bus.UART_Tx_DATA), 32'(e[7:0]));
        chk("send_ack",  32'(bus.ack), 32'(1) << e[10:8]);
      end
    end else begin
      chk("idle_ack", 32'(bus.ack), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst = 1'b1;
    bus.err_clr = 1'b0;
    bus.UART_Tx_FULL = 1'b0;
    drive();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_send",  32'(bus.UART_send), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_err",   32'(bus.timeout_err), 32'd0);
    chk("rst_data",  32'(bus.UART_Tx_DATA), 32'h10);
    chk("rst_rrptr", 32'(dut.rr_ptr_q), 32'd0);
    @(posedge clk); #3 rst = 1'b0;

    // Single two-byte packet on source 1, cycle-exact
    @(posedge clk); #3;
    tx(1, 8'hA5, 1'b0); tx(1, 8'h01, 1'b1);
    expect_byte(1, 8'hA5); expect_byte(1, 8'h01);
    drive();
    @(negedge clk);
    chk("sp_c0_send", 32'(bus.UART_send), 32'd0);
    chk("sp_c0_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("sp_c1_send", 32'(bus.UART_send), 32'd1);
    chk("sp_c1_data", 32'(bus.UART_Tx_DATA), 32'hA5);
    @(negedge clk);
    chk("sp_c2_send", 32'(bus.UART_send), 32'd1);
    chk("sp_c2_data", 32'(bus.UART_Tx_DATA), 32'h01);
    @(negedge clk);
    chk("sp_c3_busy", 32'(bus.busy), 32'd0);
    chk("sp_c3_send", 32'(bus.UART_send), 32'd0);

    // Fairness between sources 0 and 2 (pointer sits at 2 after source 1)
    @(posedge clk); #3;
    for (int k = 0; k < 3; k++) begin
      tx(0, 8'h50 + 8'(k), 1'b1);
      tx(2, 8'h70 + 8'(k), 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      expect_byte(2, 8'h70 + 8'(k));
      expect_byte(0, 8'h50 + 8'(k));
    end
    s0 = stamps.size();
    drive();
    wait_idle("fair_done");
    chk("fair_count", 32'(stamps.size() - s0), 32'd6);
    if (stamps.size() >= s0 + 6) begin
      for (int k = 0; k < 5; k++) chk("fair_gap", 32'(stamps[s0+k+1] - stamps[s0+k]), 32'd2);
    end
    chk("fair_rrptr", 32'(dut.rr_ptr_q), 32'd1);

    // Backpressure mid-packet on source 0
    @(posedge clk); #3;
    tx(0, 8'h11, 1'b0); tx(0, 8'h22, 1'b0); tx(0, 8'h33, 1'b1);
    expect_byte(0, 8'h11); expect_byte(0, 8'h22); expect_byte(0, 8'h33);
    drive();
    wait_send("bp_first");
    @(posedge clk); #3 bus.UART_Tx_FULL = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_send", 32'(bus.UART_send), 32'd0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      chk("bp_tmo",  32'(dut.tmo_cnt_q), 32'd0);
      chk("bp_err",  32'(bus.timeout_err), 32'd0);
    end
    bus.UART_Tx_FULL = 1'b0;
    wait_idle("bp_done");
    chk("bp_err_end", 32'(bus.timeout_err), 32'd0);

    // Timeout on source 1 after one byte without last
    @(posedge clk); #3;
    tx(1, 8'h5A, 1'b0);
    expect_byte(1, 8'h5A);
    drive();
    wait_send("to_first");
    repeat (4) @(negedge clk);
    chk("to_busy_hold", 32'(bus.busy), 32'd1);
    chk("to_cnt",       32'(dut.tmo_cnt_q), 32'd3);
    @(negedge clk);
    chk("to_busy", 32'(bus.busy), 32'd0);
    chk("to_err",  32'(bus.timeout_err), 32'd1);
    chk("to_rrptr", 32'(dut.rr_ptr_q), 32'd2);
    @(posedge clk); #3 bus.err_clr = 1'b1;
    @(negedge clk);
    chk("clr_sticky", 32'(bus.timeout_err), 32'd1);
    @(negedge clk);
    chk("clr_done", 32'(bus.timeout_err), 32'd0);
    bus.err_clr = 1'b0;

    // err_clr coinciding with a fresh timeout: set wins
    @(posedge clk); #3;
    tx(1, 8'h6B, 1'b0);
    expect_byte(1, 8'h6B);
    drive();
    wait_send("to2_first");
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    chk("to2_busy", 32'(bus.busy), 32'd0);
    chk("to2_setwins", 32'(bus.timeout_err), 32'd1);
    bus.err_clr = 1'b0;
    @(posedge clk); #3 bus.err_clr = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("clr2_done", 32'(bus.timeout_err), 32'd0);
    bus.err_clr = 1'b0;

    // Atomicity: source 0 waits for source 2 to finish, then one idle bubble
    @(posedge clk); #3;
    tx(2, 8'h81, 1'b0); tx(2, 8'h82, 1'b0); tx(2, 8'h83, 1'b1);
    expect_byte(2, 8'h81); expect_byte(2, 8'h82); expect_byte(2, 8'h83);
    drive();
    wait_send("at_first");
    @(posedge clk); #3;
    tx(0, 8'h90, 1'b1);
    expect_byte(0, 8'h90);
    drive();
    s0 = stamps.size();
    wait_idle("at_done");
    chk("at_count", 32'(stamps.size() - s0), 32'd3);
    if (stamps.size() >= s0 + 3) begin
      chk("at_burst",  32'(stamps[s0+1] - stamps[s0]), 32'd1);
      chk("at_bubble", 32'(stamps[s0+2] - stamps[s0+1]), 32'd2);
    end

    // Asynchronous reset between bytes of a source-1 packet
    @(posedge clk); #3;
    tx(1, 8'hE1, 1'b0); tx(1, 8'hE2, 1'b0); tx(1, 8'hE3, 1'b1);
    tx(2, 8'hF1, 1'b1);
    expect_byte(1, 8'hE1);
    drive();
    wait_send("ar_first");
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_send", 32'(bus.UART_send), 32'd0);
    chk("ar_ack",  32'(bus.ack), 32'd0);
    pq[1].delete();
    tx(1, 8'hE1, 1'b0); tx(1, 8'hE2, 1'b0); tx(1, 8'hE3, 1'b1);
    expect_byte(1, 8'hE1); expect_byte(1, 8'hE2); expect_byte(1, 8'hE3);
    expect_byte(2, 8'hF1);
    drive();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_rrptr", 32'(dut.rr_ptr_q), 32'd0);
    wait_idle("ar_done");

    chk("exp_drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit byte stream between several packet sources: register-read responses, captured USB frames (INFO header plus DATA bytes) and a forced/status byte source.
- Grants are packet-atomic and round-robin. Once a source starts a packet, it owns the UART until it marks its last byte.
- A per-packet inactivity timeout stops a stalled source from locking the link.
- Sits between the per-source packetisers and the UART Tx buffer.

Parameters:
- N_REQ, 3, number of requesters (2..8); index 0 = register responses, 1 = USB capture, 2 = force/status.
- TIMEOUT, 255, cycles a granted requester may leave req low mid-packet before the grant is revoked (1..255).

Ports:
- clk  input  1  reference clock
- rst  input  1  asynchronous, active-high reset
- req  input  N_REQ  per-requester "byte valid"; held until acked
- data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- last  input  N_REQ  qualifies req: this byte ends the packet
- ack  output  N_REQ  one-cycle pulse; requester's byte consumed this edge
- UART_Tx_FULL  input  1  UART Tx buffer cannot accept a byte
- UART_Tx_DATA  output  8  byte to UART
- UART_send  output  1  write strobe to UART, one byte per cycle high
- grant_id  output  3  index of current owner (valid when busy)
- busy  output  1  a packet is in progress
- timeout_err  output  1  sticky; set on grant revocation
- err_clr  input  1  clears timeout_err

Behaviour:
- Reset values: state ARB_IDLE, rr_ptr=0, grant_id=0, busy=0, timeout_err=0, tmo_cnt=0.
  - Combinational outputs are therefore low on reset: ack=0, UART_send=0, UART_Tx_DATA=data of requester 0.
- States:
  - ARB_IDLE, busy=0. If any req bit is set, search from rr_ptr upward with wrap-around. The first set index is latched into grant_id, busy←1, go to ARB_XFER. No byte moves in ARB_IDLE.
  - ARB_XFER, busy=1.
    - take = req[g] & !UART_Tx_FULL, where g = grant_id.
    - UART_send = take; ack[g] = take; all other ack bits = 0.
    - UART_Tx_DATA = data[g], combinational mux, valid in every ARB_XFER cycle.
    - take & last[g]: next state ARB_IDLE, rr_ptr ← (g+1) mod N_REQ, tmo_cnt←0.
    - take & !last[g]: stay in ARB_XFER, tmo_cnt←0.
    - req[g]=0: tmo_cnt++. When tmo_cnt reaches TIMEOUT, go to ARB_IDLE, rr_ptr←(g+1) mod N_REQ, timeout_err←1, tmo_cnt←0.
    - UART_Tx_FULL with req[g]=1 is backpressure, not a stall: tmo_cnt is held.
- Latency: first byte of a packet is sent no earlier than 2 cycles after req rises from ARB_IDLE. Subsequent bytes go one per cycle while req stays high and FULL stays low.
- One mandatory ARB_IDLE bubble separates consecutive packets, including back-to-back packets from the same requester.
- Requests from non-granted sources are ignored, never acked, and never lost (they stay pending).
- A single-byte packet is req with last=1 on its first byte.
- Simultaneous events:
  - err_clr and a timeout in the same cycle: set wins.
  - UART_Tx_FULL rising in the same cycle as the last byte: no take; the packet remains open.
- Mid-packet reset: grant dropped immediately (async); ack and UART_send go low the same instant. The requester must restart its packet; no partial-packet recovery.
- A requester index ≥ N_REQ is unreachable. grant_id is zero-extended to 3 bits.

Decomposition:
- Shared package/header:
  - state encodings ARB_IDLE=0 and ARB_XFER=1;
  - requester index constants REQ_REG=0, REQ_USB=1, REQ_FORCE=2.
- One natural sub-module, rr_pick: combinational round-robin first-set search (req vector + pointer → found, index). It is reused later for op-stack source arbitration.
- The timeout counter stays inline.

Test Plan:
- Single packet: req[1] with bytes 0xA5, 0x01 (last) and FULL=0 → UART_send high for 2 consecutive cycles starting 2 cycles after req; UART_Tx_DATA 0xA5 then 0x01; ack[1] pulses twice; busy falls the cycle after.
- Fairness: req[0] and req[2] both held with 1-byte packets continuously → grant order 0, 2, 0, 2 with one idle cycle between; req[1] never acked.
- Backpressure: FULL held high for 10 cycles mid-packet on requester 0 → no ack or send, tmo_cnt stays 0, no timeout_err; the packet completes once FULL drops.
- Timeout: TIMEOUT=4; requester 1 sends 1 byte (no last) then drops req → after 4 cycles busy=0, timeout_err=1, rr_ptr=2. Pulsing err_clr clears it; err_clr in the same cycle as a new timeout leaves it at 1.
- Atomicity: requester 2 mid-packet while req[0] rises → req[0] is not acked until requester 2's last byte, then granted after one idle cycle.
- Async reset mid-packet: rst pulsed between bytes → busy, ack and UART_send go low without a clock edge; after release, rr_ptr=0 and the lowest pending index wins.
